// File: rtl/uart_tx_buffer.sv
// Memory-mapped UART transmitter: CPU stores fill a byte FIFO that an 8N1
// serializer drains onto tx; an optional level irq reports a fully drained channel.
module uart_tx_buffer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BAUD_DIV  = 5208,
    parameter logic [31:0] ADDR_DATA = 32'h4000_0030,
    parameter logic [31:0] ADDR_STAT = 32'h4000_0034,
    parameter logic [31:0] ADDR_CTRL = 32'h4000_0038
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q, irq_q, irq_en_q, ovf_q;

    logic          data_wr, ctrl_wr, empty, full, busy, pop, push, ovf_evt, baud_end;
    logic [3:0]    count_disp;
    logic          unused_wdata;

    assign data_wr    = wr && (addr == ADDR_DATA);
    assign ctrl_wr    = wr && (addr == ADDR_CTRL);
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign busy       = (state_q != S_IDLE);
    assign pop        = (state_q == S_IDLE) && !empty;
    // A full FIFO still takes the byte when the serializer frees a slot on this edge.
    assign push       = data_wr && (!full || pop);
    assign ovf_evt    = data_wr && !push;
    assign baud_end   = (baud_q == BW'(BAUD_DIV - 1));
    assign count_disp = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
    assign unused_wdata = ^wdata[31:8];

    assign tx  = tx_q;
    assign irq = irq_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        rdata = '0;
        if (rd && addr == ADDR_STAT) begin
            rdata = {24'b0, ovf_q, busy, full, empty, count_disp};
        end else if (rd && addr == ADDR_CTRL) begin
            rdata = {31'b0, irq_en_q};
        end
    end

    // Storage array carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            irq_q    <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            irq_q   <= irq_en_q && empty && !busy;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (ctrl_wr) begin
                irq_en_q <= wdata[0];
            end
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (ctrl_wr && wdata[1]) begin
                ovf_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q  <= mem_q[rd_ptr_q];
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                        bit_q    <= '0;
                        baud_q   <= '0;
                        tx_q     <= 1'b0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_end) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized bench for uart_tx_buffer: a queue-level reference model predicts bus,
// tx and irq behaviour; a line monitor decodes frames against a byte scoreboard.
module tb_uart_tx_buffer;
    localparam int DEPTH = 16;
    localparam int B     = 4;
    localparam logic [31:0] A_DATA = 32'h4000_0030;
    localparam logic [31:0] A_STAT = 32'h4000_0034;
    localparam logic [31:0] A_CTRL = 32'h4000_0038;
    localparam logic [31:0] A_MISS = 32'h4000_003C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    always #5 clk = ~clk;

    uart_tx_buffer #(.DEPTH(DEPTH), .BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: FIFO contents, cycles left in the current frame, control bits.
    logic [7:0]  model_q[$];
    logic [7:0]  sb_q[$];
    int          m_ser_left = 0;
    logic [7:0]  m_cur = '0;
    logic        m_irq_en = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_irq = 1'b0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int phase;
        int bitn;
        if (m_ser_left == 0) return 1'b1;
        phase = 10 * B - m_ser_left;
        bitn  = phase / B;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return m_cur[bitn-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_rdata(input logic r, input logic [31:0] a);
        int cnt;
        int disp;
        if (!r) return 32'h0;
        cnt  = model_q.size();
        disp = (cnt > 15) ? 15 : cnt;
        if (a == A_STAT)
            return {24'b0, m_ovf, (m_ser_left != 0), (cnt == DEPTH), (cnt == 0), 4'(disp)};
        if (a == A_CTRL) return {31'b0, m_irq_en};
        return 32'h0;
    endfunction

    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic irq_new;
        logic ovf_evt;
        irq_new = m_irq_en && (model_q.size() == 0) && (m_ser_left == 0);
        ovf_evt = 1'b0;
        if (m_ser_left == 0 && model_q.size() != 0) begin
            m_cur = model_q.pop_front();
            m_ser_left = 10 * B;
        end else if (m_ser_left > 0) begin
            m_ser_left--;
        end
        if (w && a == A_DATA) begin
            if (model_q.size() < DEPTH) begin
                model_q.push_back(d[7:0]);
                sb_q.push_back(d[7:0]);
            end else begin
                ovf_evt = 1'b1;
            end
        end
        if (w && a == A_CTRL) begin
            m_irq_en = d[0];
            if (d[1]) m_ovf = 1'b0;
        end
        if (ovf_evt) m_ovf = 1'b1;
        m_irq = irq_new;
    endtask

    // One bus cycle, entered and left at a falling clock edge.
    task automatic cycle(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd = r; wr = w; addr = a; wdata = d;
        #2;
        last_rdata = rdata;
        check("rdata", rdata, model_rdata(r, a));
        @(posedge clk);
        model_edge(w, a, d);
        @(negedge clk);
        check("tx", 32'(tx), 32'(model_tx()));
        check("irq", 32'(irq), 32'(m_irq));
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic idle(input int n);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 3))
                0: a = A_STAT;
                1: a = A_CTRL;
                2: a = A_DATA;
                default: a = A_MISS;
            endcase
            cycle(1'($urandom_range(0, 1)), 1'b0, a, $urandom);
        end
    endtask

    function automatic logic in_data_low();
        int phase;
        phase = 10 * B - m_ser_left;
        return (m_ser_left != 0) && (phase >= B) && (phase < 9 * B) && (model_tx() == 1'b0);
    endfunction

    // Line monitor: decodes each frame at bit centres and pops the scoreboard.
    initial begin
        int cnt;
        bit active;
        logic [7:0] byt;
        active = 0;
        cnt = 0;
        byt = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 0;
                continue;
            end
            if (!active) begin
                if (tx === 1'b0) begin
                    active = 1;
                    cnt = 0;
                end
            end else begin
                cnt++;
            end
            if (active) begin
                if (cnt == B / 2) check("start_bit", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++)
                    if (cnt == B * (1 + i) + B / 2) byt[i] = tx;
                if (cnt == 9 * B + B / 2) begin
                    check("stop_bit", 32'(tx), 32'd1);
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL frame_unexpected: got byte 0x%0h expected no frame", byt);
                    end else begin
                        check("frame_byte", 32'(byt), 32'(sb_q.pop_front()));
                    end
                    active = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        // Reset and idle bus behaviour.
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        cycle(1'b1, 1'b0, A_STAT, 32'h0);
        check("stat_after_reset", last_rdata, 32'h10);
        cycle(1'b1, 1'b0, A_DATA, 32'h0);
        check("read_data_reg", last_rdata, 32'h0);
        cycle(1'b1, 1'b0, A_MISS, 32'h0);
        check("read_unmapped", last_rdata, 32'h0);

        // Single 0x55 frame.
        cycle(1'b0, 1'b1, A_DATA, 32'hFFFF_FF55);
        idle(46);

        // Interrupt on drain, then disable.
        cycle(1'b0, 1'b1, A_CTRL, 32'h1);
        cycle(1'b0, 1'b1, A_DATA, 32'h0000_00A3);
        idle(50);
        check("irq_after_drain", 32'(irq), 32'd1);
        cycle(1'b0, 1'b1, A_CTRL, 32'h0);
        idle(3);

        // 17 back-to-back pushes, then an overflowing 18th.
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, A_DATA, $urandom);
        cycle(1'b0, 1'b1, A_DATA, $urandom);
        cycle(1'b1, 1'b0, A_STAT, 32'h0);
        check("stat_overflow", last_rdata, 32'hEF);
        cycle(1'b0, 1'b1, A_CTRL, 32'h2);
        cycle(1'b1, 1'b0, A_STAT, 32'h0);
        check("stat_ovf_cleared", last_rdata, 32'h6F);

        // Push into a full FIFO on the very edge the serializer pops.
        guard = 0;
        while (!(m_ser_left == 0 && model_q.size() == DEPTH) && guard < 100) begin
            cycle(1'b1, 1'b0, A_STAT, 32'h0);
            guard++;
        end
        check("full_pop_reached", 32'(guard < 100), 32'd1);
        cycle(1'b0, 1'b1, A_DATA, $urandom);
        cycle(1'b1, 1'b0, A_STAT, 32'h0);
        check("stat_full_push_pop", last_rdata, 32'h6F);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 11))
                0, 1, 2: idle(1);
                3, 4:    cycle(1'b1, 1'b0, ($urandom_range(0, 1) != 0) ? A_STAT : A_CTRL, 32'h0);
                5, 6:    cycle(1'b0, 1'b1, A_DATA, $urandom);
                7:       cycle(1'b0, 1'b1, A_CTRL, 32'($urandom_range(0, 3)));
                8:       cycle(1'b0, 1'b1, ($urandom_range(0, 1) != 0) ? A_STAT : A_MISS, $urandom);
                default: idle(4);
            endcase
        end

        // Reset in the middle of a low data bit.
        if (m_ser_left == 0 && model_q.size() == 0) cycle(1'b0, 1'b1, A_DATA, 32'h00);
        guard = 0;
        while (!in_data_low() && guard < 2000) begin
            if (model_q.size() == 0 && m_ser_left == 0) cycle(1'b0, 1'b1, A_DATA, 32'h00);
            else idle(1);
            guard++;
        end
        check("data_low_reached", 32'(guard < 2000), 32'd1);
        cycle(1'b0, 1'b1, A_DATA, $urandom);
        if (!in_data_low()) idle(1);
        #3 reset = 1'b1;
        #1;
        check("async_reset_tx", 32'(tx), 32'd1);
        model_q.delete();
        sb_q.delete();
        m_ser_left = 0;
        m_irq_en = 1'b0;
        m_ovf = 1'b0;
        m_irq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 1'b0, A_STAT, 32'h0);
        check("stat_after_mid_reset", last_rdata, 32'h10);
        idle(60);

        // Traffic still works after reset; drain and confirm nothing left over.
        cycle(1'b0, 1'b1, A_DATA, $urandom);
        cycle(1'b0, 1'b1, A_DATA, $urandom);
        guard = 0;
        while ((model_q.size() != 0 || m_ser_left != 0) && guard < 3000) begin
            idle(1);
            guard++;
        end
        check("drain_done", 32'(guard < 3000), 32'd1);
        idle(5);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
